// File: rtl/game_pkg.sv
// Shared definitions for the Play-mode round controller and the menu FSM.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } round_state_t;

  // Fibonacci feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7,5,4,3)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam int unsigned DEFAULT_ROUNDS     = 10;
  localparam int unsigned DEFAULT_ROUND_TIME = 30;

  function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/game_round_sequencer_if.sv
// Menu/display-side signal bundle of the round controller.
interface game_round_sequencer_if;
  logic       start;
  logic       CEN;
  logic       Select;
  logic       Quit;
  logic [7:0] userNumber;
  logic [7:0] targetNumber;
  logic [5:0] timeLeft;
  logic [7:0] score;
  logic [3:0] roundNum;
  logic       correctPulse;
  logic       wrongPulse;
  logic       gameDone;
  logic       q_Idle;
  logic       q_Load;
  logic       q_Wait;
  logic       q_Check;
  logic       q_Done;

  modport master (
    output start, CEN, Select, Quit, userNumber,
    input  targetNumber, timeLeft, score, roundNum, correctPulse, wrongPulse,
           gameDone, q_Idle, q_Load, q_Wait, q_Check, q_Done
  );

  modport slave (
    input  start, CEN, Select, Quit, userNumber,
    output targetNumber, timeLeft, score, roundNum, correctPulse, wrongPulse,
           gameDone, q_Idle, q_Load, q_Wait, q_Check, q_Done
  );
endinterface

// File: rtl/game_round_sequencer_round_timer.sv
// Per-round countdown: tick prescaler plus remaining-ticks down-counter.
module round_timer #(
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned ROUND_TIME = 30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       clear,
  input  logic       load,
  input  logic       enable,
  output logic [5:0] timeLeft,
  output logic       timeout
);

  localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [5:0]    TIME_INIT = 6'(ROUND_TIME);

  logic [PW-1:0] prescaler;
  logic          wrap;

  assign wrap    = enable && (prescaler == PRE_LAST);
  assign timeout = wrap && (timeLeft == 6'd1);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prescaler <= '0;
      timeLeft  <= '0;
    end else if (clear) begin
      prescaler <= '0;
      timeLeft  <= '0;
    end else if (load) begin
      prescaler <= '0;
      timeLeft  <= TIME_INIT;
    end else if (enable) begin
      prescaler <= wrap ? '0 : prescaler + PW'(1);
      if (wrap && (timeLeft != '0))
        timeLeft <= timeLeft - 6'd1;
    end
  end

endmodule

// File: rtl/game_round_sequencer.sv
// Play-mode round controller: target generation, per-round countdown,
// answer comparison, score/round bookkeeping and game-over handshake.
module game_round_sequencer
  import game_pkg::*;
#(
  parameter int unsigned ROUNDS     = DEFAULT_ROUNDS,
  parameter int unsigned TICK_DIV   = 50_000_000,
  parameter int unsigned ROUND_TIME = DEFAULT_ROUND_TIME,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input logic                   Clk,
  input logic                   Reset_n,
  game_round_sequencer_if.slave bus
);

  localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

  round_state_t state, nextState;

  logic       btnSel, btnQuit;
  logic [7:0] lfsr;
  logic [7:0] targetReg, scoreReg, userCapt;
  logic [3:0] roundReg;
  logic       timeoutFlag, correctReg, wrongReg, doneReg;
  logic       timerClear, timerLoad, timerEnable, timerTimeout;
  logic [5:0] timeLeft;
  logic       match, lastRound;

  assign btnSel    = bus.CEN & bus.Select;
  assign btnQuit   = bus.CEN & bus.Quit;
  assign match     = !timeoutFlag && (userCapt == targetReg);
  assign lastRound = (roundReg == LAST_ROUND);

  // Timer controls decode state only, so timeout never loops back through them
  assign timerClear  = (state == IDLE) && bus.start;
  assign timerLoad   = (state == LOAD) && !btnQuit;
  assign timerEnable = (state == WAIT);

  round_timer #(
    .TICK_DIV   (TICK_DIV),
    .ROUND_TIME (ROUND_TIME)
  ) uTimer (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .clear    (timerClear),
    .load     (timerLoad),
    .enable   (timerEnable),
    .timeLeft (timeLeft),
    .timeout  (timerTimeout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  if (bus.start) nextState = LOAD;
      LOAD:  nextState = btnQuit ? DONE : WAIT;
      WAIT: begin
        if (btnQuit)                     nextState = DONE;
        else if (btnSel || timerTimeout) nextState = CHECK;
      end
      CHECK: begin
        if (btnQuit || lastRound) nextState = DONE;
        else                      nextState = LOAD;
      end
      DONE:  if (btnSel) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      lfsr        <= LFSR_SEED;
      targetReg   <= '0;
      scoreReg    <= '0;
      userCapt    <= '0;
      roundReg    <= '0;
      timeoutFlag <= 1'b0;
      correctReg  <= 1'b0;
      wrongReg    <= 1'b0;
      doneReg     <= 1'b0;
    end else begin
      lfsr       <= lfsrNext(lfsr);
      correctReg <= 1'b0;
      wrongReg   <= 1'b0;
      doneReg    <= (nextState == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            scoreReg  <= '0;
            roundReg  <= '0;
            targetReg <= '0;
          end
        end
        LOAD: begin
          if (!btnQuit) targetReg <= lfsr;
        end
        WAIT: begin
          // A press on the timeout cycle wins and is judged on its value
          if (!btnQuit && btnSel) begin
            userCapt    <= bus.userNumber;
            timeoutFlag <= 1'b0;
          end else if (!btnQuit && timerTimeout) begin
            timeoutFlag <= 1'b1;
          end
        end
        CHECK: begin
          if (!btnQuit) begin
            if (match) begin
              if (scoreReg != 8'hFF) scoreReg <= scoreReg + 8'd1;
              correctReg <= 1'b1;
            end else begin
              wrongReg <= 1'b1;
            end
            if (!lastRound) roundReg <= roundReg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.targetNumber = targetReg;
  assign bus.timeLeft     = timeLeft;
  assign bus.score        = scoreReg;
  assign bus.roundNum     = roundReg;
  assign bus.correctPulse = correctReg;
  assign bus.wrongPulse   = wrongReg;
  assign bus.gameDone     = doneReg;

  assign bus.q_Idle  = (state == IDLE);
  assign bus.q_Load  = (state == LOAD);
  assign bus.q_Wait  = (state == WAIT);
  assign bus.q_Check = (state == CHECK);
  assign bus.q_Done  = (state == DONE);

endmodule
